// File: rtl/fwd_pipe_ctrl.sv
// rtl/fwd_pipe_ctrl.sv - EX/MEM and MEM/WB pipeline registers with operand forwarding and load-use detection
// Optional FWD_STATS_EN adds a saturating forwarding-event counter on fwd_count_o.
module fwd_pipe_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hold_i,
  input  logic          flush_i,
  input  logic [AW-1:0] id_ex_rs_i,
  input  logic [AW-1:0] id_ex_rt_i,
  input  logic [AW-1:0] ex_rd_i,
  input  logic          ex_regwrite_i,
  input  logic          ex_memtoreg_i,
  input  logic [DW-1:0] ex_result_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [1:0]    fwd_a_o,
  output logic [1:0]    fwd_b_o,
  output logic [DW-1:0] exmem_result_o,
  output logic [DW-1:0] wb_data_o,
  output logic [AW-1:0] wb_rd_o,
  output logic          wb_regwrite_o,
  output logic          load_hazard_o
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]   fwd_count_o
`endif
);

  logic [AW-1:0] exmem_rd;
  logic          exmem_regwrite;
  logic          exmem_memtoreg;
  logic [DW-1:0] exmem_result;
  logic [AW-1:0] memwb_rd;
  logic          memwb_regwrite;
  logic [DW-1:0] memwb_data;

  // A flush turns the EX/MEM entry into a bubble; hold freezes both stages and drops the flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exmem_rd       <= '0;
      exmem_regwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_result   <= '0;
      memwb_rd       <= '0;
      memwb_regwrite <= 1'b0;
      memwb_data     <= '0;
    end else if (!hold_i) begin
      exmem_rd       <= flush_i ? '0 : ex_rd_i;
      exmem_regwrite <= flush_i ? 1'b0 : ex_regwrite_i;
      exmem_memtoreg <= flush_i ? 1'b0 : ex_memtoreg_i;
      exmem_result   <= flush_i ? '0 : ex_result_i;
      memwb_rd       <= exmem_rd;
      memwb_regwrite <= exmem_regwrite;
      memwb_data     <= exmem_memtoreg ? mem_rdata_i : exmem_result;
    end
  end

  logic exmem_live;
  logic memwb_live;
  logic exmem_alu;

  assign exmem_live = exmem_regwrite && (exmem_rd != '0);
  assign memwb_live = memwb_regwrite && (memwb_rd != '0);
  assign exmem_alu  = exmem_live && !exmem_memtoreg;

  // A load in EX/MEM has no data yet, so its match falls through to the older stage.
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (exmem_alu && (exmem_rd == id_ex_rs_i))
      fwd_a_o = 2'b01;
    else if (memwb_live && (memwb_rd == id_ex_rs_i))
      fwd_a_o = 2'b10;
    if (exmem_alu && (exmem_rd == id_ex_rt_i))
      fwd_b_o = 2'b01;
    else if (memwb_live && (memwb_rd == id_ex_rt_i))
      fwd_b_o = 2'b10;
  end

  assign load_hazard_o  = exmem_live && exmem_memtoreg &&
                          ((exmem_rd == id_ex_rs_i) || (exmem_rd == id_ex_rt_i));
  assign exmem_result_o = exmem_result;
  assign wb_data_o      = memwb_data;
  assign wb_rd_o        = memwb_rd;
  assign wb_regwrite_o  = memwb_regwrite;

`ifdef FWD_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      fwd_count_o <= '0;
    else if (!hold_i && ((fwd_a_o != 2'b00) || (fwd_b_o != 2'b00)) && (fwd_count_o != 16'hFFFF))
      fwd_count_o <= fwd_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_pipe_ctrl.sv
// tb/tb_fwd_pipe_ctrl.sv - scoreboard bench for fwd_pipe_ctrl
module tb_fwd_pipe_ctrl;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] ld;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic        rw = 1'b0, mtr = 1'b0;
  logic [31:0] res = '0, mem_rdata = '0, cur_ld = '0;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] exmem_result, wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, load_hazard;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  ent_t wbe;

  fwd_pipe_ctrl #(.DW(32), .AW(5)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .id_ex_rs_i(rs), .id_ex_rt_i(rt), .ex_rd_i(rd),
    .ex_regwrite_i(rw), .ex_memtoreg_i(mtr), .ex_result_i(res),
    .mem_rdata_i(mem_rdata), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .exmem_result_o(exmem_result), .wb_data_o(wb_data), .wb_rd_o(wb_rd),
    .wb_regwrite_o(wb_regwrite), .load_hazard_o(load_hazard)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] fsel(input logic [4:0] r);
    if (q[0].rw && q[0].rd != 0 && q[0].rd == r && !q[0].mtr) return 2'b01;
    if (wbe.rw && wbe.rd != 0 && wbe.rd == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    ent_t z;
    z = '{default: '0};
    q = {};
    q.push_back(z);
    wbe = z;
    mem_rdata = '0;
  endtask

  task automatic drive(input logic [4:0] d, input logic w, input logic m, input logic [31:0] r,
                       input logic [31:0] l, input logic [4:0] s, input logic [4:0] t);
    rd = d; rw = w; mtr = m; res = r; cur_ld = l; rs = s; rt = t;
  endtask

  // Scoreboard: entry pushed when the instruction is clocked in, popped when it reaches MEM/WB.
  task automatic tick();
    ent_t e;
    logic        hz;
    logic [31:0] wd;
    #1;
    hz = q[0].rw && q[0].mtr && q[0].rd != 0 && (q[0].rd == rs || q[0].rd == rt);
    checks++;
    if (fwd_a !== fsel(rs)) begin errors++; $display("FAIL model_fwd_a: got %b expected %b", fwd_a, fsel(rs)); end
    checks++;
    if (fwd_b !== fsel(rt)) begin errors++; $display("FAIL model_fwd_b: got %b expected %b", fwd_b, fsel(rt)); end
    checks++;
    if (load_hazard !== hz) begin errors++; $display("FAIL model_hazard: got %b expected %b", load_hazard, hz); end
    @(posedge clk);
    if (!hold) begin
      e.rw = flush ? 1'b0 : rw;
      e.mtr = flush ? 1'b0 : mtr;
      e.rd = flush ? 5'd0 : rd;
      e.res = flush ? 32'd0 : res;
      e.ld = flush ? 32'd0 : cur_ld;
      q.push_back(e);
      wbe = q.pop_front();
    end
    #1;
    wd = wbe.mtr ? wbe.ld : wbe.res;
    checks++;
    if (wb_regwrite !== wbe.rw) begin errors++; $display("FAIL sb_wb_regwrite: got %b expected %b", wb_regwrite, wbe.rw); end
    checks++;
    if (wb_rd !== wbe.rd) begin errors++; $display("FAIL sb_wb_rd: got %0d expected %0d", wb_rd, wbe.rd); end
    checks++;
    if (wb_data !== wd) begin errors++; $display("FAIL sb_wb_data: got %h expected %h", wb_data, wd); end
    checks++;
    if (exmem_result !== q[0].res) begin errors++; $display("FAIL sb_exmem_result: got %h expected %h", exmem_result, q[0].res); end
    mem_rdata = q[0].ld;
  endtask

  task automatic test_reset();
    drive(5'd1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd0, 5'd0); tick();
    drive(5'd2, 1'b1, 1'b0, 32'h22, 32'h0, 5'd2, 5'd1); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wb_regwrite, wb_rd, wb_data, exmem_result} !== '0) begin
      errors++; $display("FAIL reset_regs: got %b/%0d/%h/%h expected all 0", wb_regwrite, wb_rd, wb_data, exmem_result);
    end
    checks++;
    if ({fwd_a, fwd_b, load_hazard} !== 5'b0) begin
      errors++; $display("FAIL reset_fwd: got %b %b %b expected 0", fwd_a, fwd_b, load_hazard);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL reset_no_wb: got %b expected 0", wb_regwrite); end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(5'd5, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd0, 5'd0); tick();
    drive(5'd6, 1'b1, 1'b0, 32'h55, 32'h0, 5'd5, 5'd0); #1;
    checks++;
    if (fwd_a !== 2'b01) begin errors++; $display("FAIL b2b_fwd_a_exmem: got %b expected 01", fwd_a); end
    checks++;
    if (exmem_result !== 32'h1234) begin errors++; $display("FAIL b2b_exmem: got %h expected 00001234", exmem_result); end
    tick();
    drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd0); #1;
    checks++;
    if (fwd_a !== 2'b10) begin errors++; $display("FAIL b2b_fwd_a_memwb: got %b expected 10", fwd_a); end
    checks++;
    if (wb_data !== 32'h1234) begin errors++; $display("FAIL b2b_wb_data: got %h expected 00001234", wb_data); end
    tick();
  endtask

  task automatic test_double_match();
    drive(5'd7, 1'b1, 1'b0, 32'hBBBB, 32'h0, 5'd0, 5'd0); tick();
    drive(5'd7, 1'b1, 1'b0, 32'hAAAA, 32'h0, 5'd0, 5'd0); tick();
    drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7); #1;
    checks++;
    if (fwd_b !== 2'b01) begin errors++; $display("FAIL dbl_fwd_b: got %b expected 01", fwd_b); end
    tick();
    drive(5'd0, 1'b1, 1'b0, 32'h1, 32'h0, 5'd0, 5'd0); tick();
    drive(5'd0, 1'b1, 1'b0, 32'h2, 32'h0, 5'd0, 5'd0); tick();
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL r0_no_fwd: got %b %b expected 00 00", fwd_a, fwd_b); end
  endtask

  task automatic test_load_use();
    drive(5'd3, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 5'd0, 5'd0); tick();
    drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd0); #1;
    checks++;
    if (load_hazard !== 1'b1) begin errors++; $display("FAIL lu_hazard: got %b expected 1", load_hazard); end
    checks++;
    if (fwd_a !== 2'b00) begin errors++; $display("FAIL lu_fwd_a: got %b expected 00", fwd_a); end
    tick();
    drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd0); #1;
    checks++;
    if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lu_wb_data: got %h expected deadbeef", wb_data); end
    checks++;
    if (fwd_a !== 2'b10) begin errors++; $display("FAIL lu_fwd_a_memwb: got %b expected 10", fwd_a); end
    tick();
  endtask

  task automatic test_hold();
    drive(5'd4, 1'b1, 1'b0, 32'h44, 32'h0, 5'd0, 5'd0); tick();
    drive(5'd8, 1'b1, 1'b0, 32'h88, 32'h0, 5'd4, 5'd8); tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 2);
      drive(5'($urandom_range(1, 31)), 1'b1, 1'b0, $urandom, $urandom, 5'd4, 5'd8);
      mem_rdata = $urandom;
      tick();
      checks++;
      if (exmem_result !== 32'h88 || wb_data !== 32'h44) begin
        errors++; $display("FAIL hold_data: got %h %h expected 88 44", exmem_result, wb_data);
      end
      checks++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin
        errors++; $display("FAIL hold_sel: got %b %b expected 10 01", fwd_a, fwd_b);
      end
    end
    hold = 1'b0; flush = 1'b0;
    mem_rdata = q[0].ld;
    drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0); tick();
    checks++;
    if (wb_regwrite !== 1'b1 || wb_rd !== 5'd8) begin
      errors++; $display("FAIL hold_no_bubble: got %b/%0d expected 1/8", wb_regwrite, wb_rd);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    drive(5'd9, 1'b1, 1'b0, 32'h99, 32'h0, 5'd0, 5'd0); tick();
    flush = 1'b0;
    drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd0); #1;
    checks++;
    if (fwd_a !== 2'b00) begin errors++; $display("FAIL flush_fwd_a: got %b expected 00", fwd_a); end
    tick();
    checks++;
    if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL flush_wb_regwrite: got %b expected 0", wb_regwrite); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      hold = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 5) == 0);
      drive(5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end
    hold = 1'b0; flush = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_back_to_back();
    test_double_match();
    test_load_use();
    test_hold();
    test_flush();
    test_random();
    test_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
